pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall bits, jump flush/redirect,
// memory timeout detection and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inst_is_load_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic             rs1_re_i,
  input  logic             rs2_re_i,
  input  logic             exe_busy_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  input  logic             jump_req_i,
  input  logic [31:0]      jump_addr_i,
  output logic [5:0]       stall_o,
  output logic             flush_jump_o,
  output logic [31:0]      jump_addr_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned TMO_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EXE_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  state_e             state_r, state_next_s;
  logic               pend_r, pend_next_s;
  logic [31:0]        pend_addr_r, pend_addr_next_s;
  logic [TMO_W-1:0]   tmo_cnt_r, tmo_cnt_next_s;
  logic [CNT_W-1:0]   stall_cnt_r, stall_cnt_next_s;

  logic               timeout_s;
  logic               mem_wait_s;
  logic               any_wait_s;
  logic               load_use_s;
  logic [5:0]         stall_s;
  logic               flush_s;
  logic [31:0]        jaddr_s;
  logic               berr_s;

  // Hazard classification; a timeout releases the memory stall in its own cycle.
  always_comb begin
    timeout_s  = (state_r == MEM_WAIT) && !mem_ack_i &&
                 (tmo_cnt_r == TMO_W'(MEM_TIMEOUT));
    mem_wait_s = !timeout_s && !mem_ack_i && (mem_req_i || (state_r == MEM_WAIT));
    any_wait_s = mem_wait_s || exe_busy_i;
    load_use_s = inst_is_load_i && (rd_i != 5'd0) &&
                 ((rs1_re_i && (rs1_i == rd_i)) || (rs2_re_i && (rs2_i == rd_i)));
  end

  // Output decode in priority order: mem wait, exe wait, jump, load-use.
  always_comb begin
    stall_s = 6'b000000;
    flush_s = 1'b0;
    jaddr_s = 32'h0000_0000;
    berr_s  = 1'b0;
    if (rst_i) begin
      stall_s = 6'b000000;
    end else begin
      berr_s = timeout_s;
      if (mem_wait_s) begin
        stall_s = 6'b011111;
      end else if (exe_busy_i) begin
        stall_s = 6'b001111;
      end else if (pend_r) begin
        flush_s = 1'b1;
        jaddr_s = pend_addr_r;
      end else if (jump_req_i) begin
        flush_s = 1'b1;
        jaddr_s = jump_addr_i;
      end else if (load_use_s) begin
        stall_s = 6'b000111;
      end else begin
        stall_s = 6'b000000;
      end
    end
  end

  // Next-state logic for FSM, deferred jump, timeout and stall counters.
  always_comb begin
    state_next_s     = state_r;
    pend_next_s      = pend_r;
    pend_addr_next_s = pend_addr_r;
    tmo_cnt_next_s   = tmo_cnt_r;
    stall_cnt_next_s = stall_cnt_r;

    case (state_r)
      RUN: begin
        if (mem_wait_s) begin
          state_next_s   = MEM_WAIT;
          tmo_cnt_next_s = {TMO_W{1'b0}};
        end else if (exe_busy_i) begin
          state_next_s = EXE_WAIT;
        end else begin
          state_next_s = RUN;
        end
      end
      EXE_WAIT: begin
        if (mem_wait_s) begin
          state_next_s   = MEM_WAIT;
          tmo_cnt_next_s = {TMO_W{1'b0}};
        end else if (!exe_busy_i) begin
          state_next_s = RUN;
        end else begin
          state_next_s = EXE_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_ack_i || timeout_s) begin
          state_next_s = RUN;
        end else begin
          tmo_cnt_next_s = tmo_cnt_r + TMO_W'(1);
        end
      end
      default: begin
        state_next_s   = RUN;
        tmo_cnt_next_s = {TMO_W{1'b0}};
      end
    endcase

    // The first jump seen during a wait is held until the pipeline drains.
    if (any_wait_s) begin
      if (jump_req_i && !pend_r) begin
        pend_next_s      = 1'b1;
        pend_addr_next_s = jump_addr_i;
      end else begin
        pend_next_s = pend_r;
      end
    end else begin
      pend_next_s = 1'b0;
    end

    if ((stall_s != 6'b000000) && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_next_s = stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_next_s = stall_cnt_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= RUN;
      pend_r      <= 1'b0;
      pend_addr_r <= 32'h0000_0000;
      tmo_cnt_r   <= {TMO_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_next_s;
      pend_r      <= pend_next_s;
      pend_addr_r <= pend_addr_next_s;
      tmo_cnt_r   <= tmo_cnt_next_s;
      stall_cnt_r <= stall_cnt_next_s;
    end
  end

  assign stall_o      = stall_s;
  assign flush_jump_o = flush_s;
  assign jump_addr_o  = jaddr_s;
  assign bus_err_o    = berr_s;
  assign stall_cnt_o  = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: expected outputs are queued as
// each step is driven and compared against the DUT before the next clock edge.
module tb_pipe_ctrl;

  localparam int unsigned CNT_W = 32;

  logic             clk;
  logic             rst;
  logic             ld;
  logic [4:0]       rd, rs1, rs2;
  logic             re1, re2, busy, mreq, mack, jreq;
  logic [31:0]      jaddr;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      jaddr_o;
  logic             berr;
  logic [CNT_W-1:0] scnt;

  typedef struct {
    string       tag;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] addr;
    logic        berr;
    logic        rst;
  } exp_t;

  exp_t        sb_q[$];
  int          n_eval;
  int          n_fail;
  int unsigned model_cnt;

  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .inst_is_load_i (ld),
    .rd_i           (rd),
    .rs1_i          (rs1),
    .rs2_i          (rs2),
    .rs1_re_i       (re1),
    .rs2_re_i       (re2),
    .exe_busy_i     (busy),
    .mem_req_i      (mreq),
    .mem_ack_i      (mack),
    .jump_req_i     (jreq),
    .jump_addr_i    (jaddr),
    .stall_o        (stall),
    .flush_jump_o   (flush),
    .jump_addr_o    (jaddr_o),
    .bus_err_o      (berr),
    .stall_cnt_o    (scnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle();
    rst = 1'b0; ld = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    re1 = 1'b0; re2 = 1'b0; busy = 1'b0; mreq = 1'b0; mack = 1'b0;
    jreq = 1'b0; jaddr = 32'h0;
  endtask

  // Pop the oldest expectation, compare mid-cycle, then advance one clock.
  task automatic check();
    exp_t e;
    #2;
    e = sb_q.pop_front();
    n_eval++;
    assert (stall === e.stall) else begin
      n_fail++; $error("FAIL %s stall_o obs=%b exp=%b", e.tag, stall, e.stall);
    end
    n_eval++;
    assert (flush === e.flush) else begin
      n_fail++; $error("FAIL %s flush_jump_o obs=%b exp=%b", e.tag, flush, e.flush);
    end
    n_eval++;
    assert (jaddr_o === e.addr) else begin
      n_fail++; $error("FAIL %s jump_addr_o obs=%h exp=%h", e.tag, jaddr_o, e.addr);
    end
    n_eval++;
    assert (berr === e.berr) else begin
      n_fail++; $error("FAIL %s bus_err_o obs=%b exp=%b", e.tag, berr, e.berr);
    end
    n_eval++;
    assert (scnt === CNT_W'(model_cnt)) else begin
      n_fail++; $error("FAIL %s stall_cnt_o obs=%0d exp=%0d", e.tag, scnt, model_cnt);
    end
    if (e.rst) model_cnt = 0;
    else if (e.stall != 6'b0) model_cnt++;
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [5:0] s, input logic f,
                            input logic [31:0] a, input logic b);
    exp_t e;
    e.tag = tag; e.stall = s; e.flush = f; e.addr = a; e.berr = b; e.rst = rst;
    sb_q.push_back(e);
    check();
  endtask

  initial begin
    n_eval = 0; n_fail = 0; model_cnt = 0;
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset gates outputs even with hazard and jump inputs present
    rst = 1'b1; ld = 1'b1; rd = 5'd5; rs1 = 5'd5; re1 = 1'b1;
    jreq = 1'b1; jaddr = 32'hDEAD_BEEF;
    expect_out("rst_gate", 6'b000000, 1'b0, 32'h0, 1'b0);
    idle();
    expect_out("post_rst", 6'b000000, 1'b0, 32'h0, 1'b0);

    // Load-use on rs1, then rd=x0, then rs2 with and without read enable
    ld = 1'b1; rd = 5'd5; rs1 = 5'd5; re1 = 1'b1;
    expect_out("lu_rs1", 6'b000111, 1'b0, 32'h0, 1'b0);
    idle();
    expect_out("lu_after", 6'b000000, 1'b0, 32'h0, 1'b0);
    ld = 1'b1; rd = 5'd0; rs1 = 5'd0; re1 = 1'b1;
    expect_out("lu_x0", 6'b000000, 1'b0, 32'h0, 1'b0);
    idle(); ld = 1'b1; rd = 5'd7; rs2 = 5'd7; re2 = 1'b1;
    expect_out("lu_rs2", 6'b000111, 1'b0, 32'h0, 1'b0);
    re2 = 1'b0;
    expect_out("lu_rs2_nore", 6'b000000, 1'b0, 32'h0, 1'b0);

    // Memory wait: four stall cycles, released on ack, back in RUN
    idle(); mreq = 1'b1;
    for (int i = 0; i < 4; i++) expect_out("mem_wait", 6'b011111, 1'b0, 32'h0, 1'b0);
    mack = 1'b1;
    expect_out("mem_ack", 6'b000000, 1'b0, 32'h0, 1'b0);
    idle(); jreq = 1'b1; jaddr = 32'h0000_0100;
    expect_out("run_jump", 6'b000000, 1'b1, 32'h0000_0100, 1'b0);

    // Jump held during multi-cycle EXE, redirected once busy drops
    idle(); busy = 1'b1; jreq = 1'b1; jaddr = 32'h8000_0040;
    for (int i = 0; i < 3; i++) expect_out("exe_busy", 6'b001111, 1'b0, 32'h0, 1'b0);
    idle();
    expect_out("pend_flush", 6'b000000, 1'b1, 32'h8000_0040, 1'b0);
    expect_out("pend_clr", 6'b000000, 1'b0, 32'h0, 1'b0);

    // Jump beats load-use in the same cycle
    jreq = 1'b1; jaddr = 32'h0000_2000; ld = 1'b1; rd = 5'd9; rs2 = 5'd9; re2 = 1'b1;
    expect_out("jump_vs_lu", 6'b000000, 1'b1, 32'h0000_2000, 1'b0);

    // Mem wait outranks exe wait; new jump ignored on the pending-flush cycle
    idle(); mreq = 1'b1; busy = 1'b1; jreq = 1'b1; jaddr = 32'h0000_3000;
    expect_out("mem_over_exe", 6'b011111, 1'b0, 32'h0, 1'b0);
    expect_out("mem_over_exe2", 6'b011111, 1'b0, 32'h0, 1'b0);
    mack = 1'b1; busy = 1'b0; jaddr = 32'h0000_4000;
    expect_out("pend_old_addr", 6'b000000, 1'b1, 32'h0000_3000, 1'b0);
    idle();
    expect_out("pend_once", 6'b000000, 1'b0, 32'h0, 1'b0);

    // Timeout without ack: stall released and one bus_err pulse
    mreq = 1'b1;
    for (int i = 0; i < 5; i++) expect_out("tmo_wait", 6'b011111, 1'b0, 32'h0, 1'b0);
    expect_out("tmo_err", 6'b000000, 1'b0, 32'h0, 1'b1);
    idle();
    expect_out("tmo_after", 6'b000000, 1'b0, 32'h0, 1'b0);

    // Ack on the timeout cycle wins over the error
    mreq = 1'b1;
    for (int i = 0; i < 5; i++) expect_out("tmo_ack_wait", 6'b011111, 1'b0, 32'h0, 1'b0);
    mack = 1'b1;
    expect_out("tmo_ack", 6'b000000, 1'b0, 32'h0, 1'b0);

    // Reset in MEM_WAIT with a pending jump discards it
    idle(); mreq = 1'b1; jreq = 1'b1; jaddr = 32'h0000_5000;
    expect_out("rst_mw1", 6'b011111, 1'b0, 32'h0, 1'b0);
    expect_out("rst_mw2", 6'b011111, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    expect_out("rst_mw_gate", 6'b000000, 1'b0, 32'h0, 1'b0);
    idle();
    expect_out("rst_no_flush", 6'b000000, 1'b0, 32'h0, 1'b0);
    expect_out("rst_no_flush2", 6'b000000, 1'b0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
